// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    // Offsets 1..NUM_REQ visit every slot once, ending at i_last itself.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((32'(i_last) + off) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with bounded bursts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_gnt,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_din,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_last_owner, w_last_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_cnt_nxt;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic             w_owner_req;
  logic             w_beat;
  logic             w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_last  (r_last_owner),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_owner_req = i_req[r_owner];

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_cnt_nxt   = r_burst_cnt;
    w_beat      = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = StGrant;
        end
      end
      StGrant: begin
        // A full FIFO stalls the burst without releasing it.
        w_beat    = w_owner_req && !i_fifo_full;
        w_release = !w_owner_req ||
                    (w_beat && (r_burst_cnt == CNT_W'(MAX_BURST - 1)));
        if (w_beat) begin
          w_cnt_nxt = r_burst_cnt + CNT_W'(1);
        end
        if (w_release) begin
          w_last_nxt  = r_owner;
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_burst_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    o_ack      = '0;
    o_gnt      = '0;
    o_fifo_din = '0;
    if (r_state == StGrant) begin
      o_gnt[r_owner] = 1'b1;
    end
    if (w_beat) begin
      o_ack[r_owner] = 1'b1;
      o_fifo_din     = i_req_data[32'(r_owner) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_fifo_wr_en = w_beat;
  assign o_busy       = (r_state == StGrant);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           wr_en;
  logic [W-1:0]   din;
  logic           busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W),
    .MAX_BURST  (MB)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_req_data   (req_data),
    .o_ack        (ack),
    .o_gnt        (gnt),
    .i_fifo_full  (fifo_full),
    .o_fifo_wr_en (wr_en),
    .o_fifo_din   (din),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner_m < 0 means no grant held.
  int owner_m, last_m, beats_m;
  int rem[N], seq[N], base[N], rd_seq[N], dut_acks[N];
  bit en[N];
  bit force_full, integ;
  int rd_pct, dut_writes, reads, cyc;
  logic [W-1:0] mf[$];
  int gnt_log[$];
  int gnt_cyc[$];
  logic [N-1:0] prev_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner_m = -1;
    last_m  = N - 1;
    beats_m = 0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; seq[i] = 0; base[i] = 0; rd_seq[i] = 0; dut_acks[i] = 0; en[i] = 1'b1;
    end
    force_full = 1'b0;
    integ      = 1'b0;
    rd_pct     = 0;
    dut_writes = 0;
    reads      = 0;
    cyc        = 0;
    mf.delete();
    gnt_log.delete();
    gnt_cyc.delete();
    prev_gnt = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (integ) en[i] = ($urandom % 8) != 0;
      req[i] = (rem[i] > 0) && en[i];
      req_data[i*W +: W] = W'(base[i] + seq[i]);
    end
    fifo_full = force_full || (integ && (mf.size() >= DEPTH));
  endtask

  // Entered and left at a negedge: drive, check, clock, then advance model and producers.
  task automatic step();
    logic [N-1:0] e_gnt, e_ack, s_ack;
    logic [W-1:0] e_din, s_din, word;
    logic         s_wr;
    bit           beat;
    int           id;
    drive();
    #1;
    beat  = (owner_m >= 0) && req[owner_m] && !fifo_full;
    e_gnt = (owner_m >= 0) ? N'(1 << owner_m) : '0;
    e_ack = beat ? N'(1 << owner_m) : '0;
    e_din = beat ? W'(base[owner_m] + seq[owner_m]) : '0;
    check("gnt", gnt, e_gnt);
    check("ack", ack, e_ack);
    check("wr_en", wr_en, beat);
    check("din", din, e_din);
    check("busy", busy, owner_m >= 0);
    check("wr_while_full", wr_en & fifo_full, 0);
    if (gnt != 0 && prev_gnt == 0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
      gnt_cyc.push_back(cyc);
    end
    prev_gnt = gnt;
    for (int i = 0; i < N; i++) if (ack[i]) dut_acks[i]++;
    if (wr_en) dut_writes++;
    s_ack = ack;
    s_wr  = wr_en;
    s_din = din;
    @(posedge clk);
    if (owner_m < 0) begin
      if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(last_m + k) % N]) begin
            owner_m = (last_m + k) % N;
            break;
          end
        end
        beats_m = 0;
      end
    end else begin
      if (beat) beats_m++;
      if (!req[owner_m] || beats_m == MB) begin
        last_m  = owner_m;
        owner_m = -1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (s_ack[i] && rem[i] > 0) begin
        seq[i]++;
        rem[i]--;
      end
    end
    if (integ) begin
      if (mf.size() > 0 && ($urandom % 100) < rd_pct) begin
        word = mf.pop_front();
        id   = int'(word[7:6]);
        check("order", word[5:0], rd_seq[id]);
        rd_seq[id]++;
        reads++;
      end
      if (s_wr && mf.size() < DEPTH) mf.push_back(s_din);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_reset();
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int log_at(input int k);
    return (k < gnt_log.size()) ? gnt_log[k] : -1;
  endfunction

  initial begin
    // Single requester: three words from producer 2.
    do_reset();
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_din", din, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    base[2] = 'hA5;
    rem[2]  = 3;
    repeat (6) step();
    check("single_acks", dut_acks[2], 3);
    check("single_writes", dut_writes, 3);
    check("single_owner", log_at(0), 2);
    check("single_gnt_cyc", gnt_cyc.size() > 0 ? gnt_cyc[0] : -1, 1);

    // All four continuous, FIFO never full.
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 100;
      base[i] = i << 6;
    end
    repeat (20) step();
    check("rr_writes_20", dut_writes, 16);
    repeat (2) step();
    for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), log_at(k), k % N);

    // Back-pressure on producer 1 after its second beat.
    do_reset();
    rem[1] = 4;
    for (int c = 0; c < 10; c++) begin
      force_full = (c >= 3 && c <= 5);
      step();
    end
    check("bp_acks", dut_acks[1], 4);
    check("bp_grants", gnt_log.size(), 1);

    // Early release by producer 0 with producer 3 waiting.
    do_reset();
    rem[0] = 2;
    rem[3] = 10;
    repeat (8) step();
    check("early_first", log_at(0), 0);
    check("early_next", log_at(1), 3);
    check("early_gap", gnt_cyc.size() > 1 ? gnt_cyc[1] - gnt_cyc[0] : -1, 4);
    check("early_acks0", dut_acks[0], 2);

    // Reset in the middle of a producer-2 burst.
    do_reset();
    rem[2] = 20;
    repeat (3) step();
    drive();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    clear_all();
    for (int i = 0; i < N; i++) rem[i] = 20;
    drive();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_owner", log_at(0), 0);

    // Integration with a depth-16 FIFO and a slow random reader.
    do_reset();
    integ  = 1'b1;
    rd_pct = 25;
    for (int i = 0; i < N; i++) begin
      rem[i]  = 8;
      base[i] = i << 6;
    end
    for (int c = 0; c < 3000 && !(reads == 4 * 8 && mf.size() == 0); c++) step();
    check("integ_reads", reads, 32);
    check("integ_left", mf.size(), 0);
    for (int i = 0; i < N; i++) check($sformatf("integ_seq%0d", i), rd_seq[i], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
